// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of Data_Memory: one request at a time, base+offset
// addressing, misalignment rejection, single-cycle access and saturating debug counters.
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [DATA_W-1:0] Req_Base,
    input  logic [15:0]       Req_Offset,
    input  logic [DATA_W-1:0] Req_WData,
    output logic              Resp_Valid,
    input  logic              Resp_Ready,
    output logic [DATA_W-1:0] Resp_Data,
    output logic              Resp_Err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData,
    output logic [CNT_W-1:0]  Load_Count,
    output logic [CNT_W-1:0]  Store_Count,
    output logic [CNT_W-1:0]  Err_Count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

    stateT             state, nextState;
    logic [DATA_W-1:0] addrSum;
    logic [ADDR_W-1:0] effAddr;
    logic              misaligned;
    logic              unusedSumBits;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    // Only the low ADDR_W bits of the sum address memory; wrap-around is intentional.
    assign addrSum       = Req_Base + {{(DATA_W-16){Req_Offset[15]}}, Req_Offset};
    assign effAddr       = addrSum[ADDR_W-1:0];
    assign unusedSumBits = &{1'b0, addrSum[DATA_W-1:ADDR_W]};
    assign misaligned    = |effAddr[2:0];

    assign Req_Ready  = (state == IDLE);
    assign Resp_Valid = (state == RESP);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= nextState;
    end

    // NOTE: next-state is assigned a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Req_Valid) nextState = misaligned ? RESP : ACCESS;
            ACCESS:  nextState = RESP;
            RESP:    if (Resp_Ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Resp_Data   <= '0;
            Resp_Err    <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            Address     <= '0;
            WriteData   <= '0;
            Load_Count  <= '0;
            Store_Count <= '0;
            Err_Count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req_Valid) begin
                        Resp_Data <= '0;
                        Resp_Err  <= misaligned;
                        if (misaligned) begin
                            Err_Count <= satInc(Err_Count);
                        end else begin
                            Address  <= effAddr;
                            MemRead  <= !Req_Write;
                            MemWrite <= Req_Write;
                            if (Req_Write) WriteData <= Req_WData;
                        end
                    end
                end
                ACCESS: begin
                    // The strobe registers double as the latched opcode for this cycle.
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    if (MemRead) begin
                        Resp_Data  <= ReadData;
                        Load_Count <= satInc(Load_Count);
                    end else begin
                        Store_Count <= satInc(Store_Count);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a transaction-level model
// of the unit and its memory; a narrow-counter twin exercises saturation.
module tb_mem_access_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 2;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b1;
    logic              Req_Valid = 1'b0;
    logic              Req_Ready;
    logic              Req_Write = 1'b0;
    logic [DATA_W-1:0] Req_Base = '0;
    logic [15:0]       Req_Offset = '0;
    logic [DATA_W-1:0] Req_WData = '0;
    logic              Resp_Valid;
    logic              Resp_Ready = 1'b0;
    logic [DATA_W-1:0] Resp_Data;
    logic              Resp_Err;
    logic              MemRead, MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData, ReadData;
    logic [CNT_W-1:0]  Load_Count, Store_Count, Err_Count;

    logic              satReqReady, satRespValid, satRespErr, satMemRead, satMemWrite;
    logic [DATA_W-1:0] satRespData, satWriteData, satReadData;
    logic [ADDR_W-1:0] satAddress;
    logic [SAT_W-1:0]  satLoadCount, satStoreCount, satErrCount;

    logic [DATA_W-1:0] mem    [32];
    logic [DATA_W-1:0] refMem [32];

    int vectors = 0;
    int miscompares = 0;
    int expLoads = 0, expStores = 0, expErrs = 0;
    logic [ADDR_W-1:0] lastAddr = '0;
    logic [DATA_W-1:0] lastWData = '0;

    always #5 Clock = ~Clock;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Base(Req_Base), .Req_Offset(Req_Offset), .Req_WData(Req_WData),
        .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Data(Resp_Data), .Resp_Err(Resp_Err),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData),
        .Load_Count(Load_Count), .Store_Count(Store_Count), .Err_Count(Err_Count)
    );

    // Same stimulus, 2-bit counters: they must stick at 3.
    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(SAT_W)) dutSat (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req_Valid(Req_Valid), .Req_Ready(satReqReady), .Req_Write(Req_Write),
        .Req_Base(Req_Base), .Req_Offset(Req_Offset), .Req_WData(Req_WData),
        .Resp_Valid(satRespValid), .Resp_Ready(Resp_Ready), .Resp_Data(satRespData), .Resp_Err(satRespErr),
        .MemRead(satMemRead), .MemWrite(satMemWrite), .Address(satAddress), .WriteData(satWriteData),
        .ReadData(satReadData),
        .Load_Count(satLoadCount), .Store_Count(satStoreCount), .Err_Count(satErrCount)
    );

    assign ReadData    = MemRead    ? mem[Address[7:3]]    : '0;
    assign satReadData = satMemRead ? mem[satAddress[7:3]] : '0;

    always @(posedge Clock) begin
        if (MemWrite) mem[Address[7:3]] <= WriteData;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] satTo(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return 64'((n > top) ? top : n);
    endfunction

    task automatic checkCounters(input string tag);
        check({tag, "_load_cnt"},      64'(Load_Count),    satTo(expLoads, CNT_W));
        check({tag, "_store_cnt"},     64'(Store_Count),   satTo(expStores, CNT_W));
        check({tag, "_err_cnt"},       64'(Err_Count),     satTo(expErrs, CNT_W));
        check({tag, "_sat_load_cnt"},  64'(satLoadCount),  satTo(expLoads, SAT_W));
        check({tag, "_sat_store_cnt"}, 64'(satStoreCount), satTo(expStores, SAT_W));
        check({tag, "_sat_err_cnt"},   64'(satErrCount),   satTo(expErrs, SAT_W));
    endtask

    function automatic int effAddrOf(input logic [63:0] base, input int off);
        return (int'(base % 256) + off + 65536) % 256;
    endfunction

    // One complete transaction: accept, optional access cycle, response held for 'hold'
    // cycles (optionally with a competing request), then handshake back to idle.
    task automatic doReq(input string tag, input bit wr, input logic [63:0] base, input int off,
                         input logic [63:0] wdata, input int hold, input bit intrude);
        int ea;
        bit mis;
        logic [63:0] expData;
        ea  = effAddrOf(base, off);
        mis = (ea % 8) != 0;
        expData = '0;

        @(negedge Clock);
        check({tag, "_req_ready"}, 64'(Req_Ready), 64'd1);
        Req_Valid = 1'b1; Req_Write = wr; Req_Base = base;
        Req_Offset = 16'(off); Req_WData = wdata; Resp_Ready = 1'b0;
        @(negedge Clock);
        Req_Valid = 1'b0;

        if (mis) begin
            expErrs++;
            check({tag, "_err_valid"}, 64'(Resp_Valid), 64'd1);
            check({tag, "_err_flag"},  64'(Resp_Err),   64'd1);
            check({tag, "_err_strobe"}, {62'd0, MemRead, MemWrite}, 64'd0);
            check({tag, "_err_addr_hold"}, 64'(Address), 64'(lastAddr));
        end else begin
            check({tag, "_acc_valid"},  64'(Resp_Valid), 64'd0);
            check({tag, "_acc_strobe"}, {62'd0, MemRead, MemWrite}, {62'd0, !wr, wr});
            check({tag, "_acc_addr"},   64'(Address), 64'(ea));
            lastAddr = 8'(ea);
            if (wr) begin
                lastWData = wdata;
                refMem[ea / 8] = wdata;
                expStores++;
            end else begin
                expData = refMem[ea / 8];
                expLoads++;
            end
            check({tag, "_acc_wdata"}, WriteData, lastWData);
            @(negedge Clock);
            check({tag, "_resp_valid"}, 64'(Resp_Valid), 64'd1);
            check({tag, "_resp_err"},   64'(Resp_Err),   64'd0);
            check({tag, "_resp_strobe"}, {62'd0, MemRead, MemWrite}, 64'd0);
        end
        check({tag, "_resp_data"}, Resp_Data, expData);
        checkCounters(tag);

        for (int i = 0; i < hold; i++) begin
            if (intrude) begin
                Req_Valid = 1'b1; Req_Write = 1'b1; Req_Base = 64'd0;
                Req_Offset = 16'd0; Req_WData = '1;
            end
            @(negedge Clock);
            check({tag, "_hold_valid"}, 64'(Resp_Valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(Req_Ready),  64'd0);
            check({tag, "_hold_data"},  Resp_Data, expData);
            check({tag, "_hold_err"},   64'(Resp_Err), 64'(mis));
            check({tag, "_hold_strobe"}, {62'd0, MemRead, MemWrite}, 64'd0);
        end
        Req_Valid = 1'b0;
        Resp_Ready = 1'b1;
        @(negedge Clock);
        Resp_Ready = 1'b0;
        check({tag, "_done_valid"}, 64'(Resp_Valid), 64'd0);
        check({tag, "_done_ready"}, 64'(Req_Ready),  64'd1);
        if (intrude) checkCounters({tag, "_intrude"});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            refMem[i] = '0;
        end

        #1 Reset_n = 1'b0;
        #20;
        check("rst_req_ready",  64'(Req_Ready),  64'd1);
        check("rst_resp_valid", 64'(Resp_Valid), 64'd0);
        check("rst_resp_err",   64'(Resp_Err),   64'd0);
        check("rst_resp_data",  Resp_Data, 64'd0);
        check("rst_strobe",     {62'd0, MemRead, MemWrite}, 64'd0);
        check("rst_addr",       64'(Address), 64'd0);
        check("rst_wdata",      WriteData, 64'd0);
        checkCounters("rst");
        @(negedge Clock);
        Reset_n = 1'b1;

        doReq("st40",   1'b1, 64'd32,   8,  64'hAAAAAAAAAAAAAAAA, 0, 1'b0);
        doReq("ld40",   1'b0, 64'd40,   0,  64'd0, 0, 1'b0);
        doReq("st80",   1'b1, 64'd88,  -8,  64'h0123456789ABCDEF, 1, 1'b0);
        doReq("ldwrap", 1'b0, 64'hF8,  88,  64'd0, 0, 1'b0);
        doReq("mis41",  1'b0, 64'd41,   0,  64'd0, 0, 1'b0);
        doReq("bp",     1'b0, 64'd80,   0,  64'd0, 5, 1'b1);

        // Reset in the middle of a store's access cycle: nothing may commit.
        @(negedge Clock);
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Base = 64'd40;
        Req_Offset = 16'd0; Req_WData = 64'h5555555555555555;
        @(negedge Clock);
        Req_Valid = 1'b0;
        check("mid_write_strobe", 64'(MemWrite), 64'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("mid_rst_strobe", {62'd0, MemRead, MemWrite}, 64'd0);
        check("mid_rst_valid",  64'(Resp_Valid), 64'd0);
        check("mid_rst_ready",  64'(Req_Ready),  64'd1);
        check("mid_rst_addr",   64'(Address), 64'd0);
        check("mid_rst_wdata",  WriteData, 64'd0);
        check("mid_rst_data",   Resp_Data, 64'd0);
        expLoads = 0; expStores = 0; expErrs = 0;
        lastAddr = '0; lastWData = '0;
        checkCounters("mid_rst");
        @(negedge Clock);
        Reset_n = 1'b1;
        doReq("ld40_after_rst", 1'b0, 64'd40, 0, 64'd0, 0, 1'b0);

        for (int i = 0; i < 5; i++) doReq("sat_mis", 1'b0, 64'd3 + 64'(i), 0, 64'd0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [63:0] base, wdata;
            int off, hold;
            bit wr, intr;
            base  = {$urandom, $urandom};
            off   = int'($urandom_range(0, 400)) - 200;
            wr    = 1'($urandom);
            wdata = {$urandom, $urandom};
            hold  = int'($urandom_range(0, 2));
            intr  = (hold > 0) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0) base = base - 64'(effAddrOf(base, off) % 8);
            doReq("rand", wr, base, off, wdata, hold, intr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
